src_pacer: RTL and testbench

- Producer end of the median-filter sample interface.
- Takes a continuous ADC sample stream and emits one sample per window of 2^PACE_LOG2 accepted ADC samples, as a single-cycle src_vld_o strobe with data. This is the sparse valid/data stream the median filter consumes.
- Sits between the ADC capture logic and the mid_filter input (src_vld_i/src_data_i).
- Also detects a stalled ADC stream and re-aligns the window.

---
 rtl/src_pacer.sv | 133 +++++++++++++
 tb/tb_src_pacer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/src_pacer.sv
// Paces a continuous ADC stream to one strobe per 2^PACE_LOG2 accepted samples, 1-cycle latency,
// no backpressure (stall = gap timeout re-arm). Define PACER_AVERAGE_EN to emit the window mean instead of the last sample.
module src_pacer #(
    parameter int DATA_WIDTH = 16,
    parameter int PACE_LOG2  = 5,
    parameter int GAP_MAX    = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  adc_vld_i,
    input  logic [DATA_WIDTH-1:0] adc_data_i,
    output logic                  src_vld_o,
    output logic [DATA_WIDTH-1:0] src_data_o,
    output logic                  stall_o,
    output logic [PACE_LOG2-1:0]  win_cnt_o
);

    localparam int GW = $clog2(GAP_MAX + 1);
    localparam logic [PACE_LOG2-1:0] WIN_LAST = '1;
    localparam logic [GW-1:0]        GAP_LAST = GW'(GAP_MAX - 1);
    localparam logic [GW-1:0]        GAP_SAT  = '1;

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t                  state, state_nxt;
    logic [PACE_LOG2-1:0]    win_cnt, win_cnt_nxt;
    logic [GW-1:0]           gap_cnt, gap_cnt_nxt;
    logic                    src_vld_nxt, stall_nxt;
    logic [DATA_WIDTH-1:0]   src_data_nxt;
    logic                    accept, close, gap_hit;

    assign accept  = en_i && adc_vld_i && (state != IDLE);
    assign close   = accept && (win_cnt == WIN_LAST);
    // A sample in the timeout cycle wins over the stall.
    assign gap_hit = en_i && (state == RUN) && !adc_vld_i && (gap_cnt == GAP_LAST);

`ifdef PACER_AVERAGE_EN
    localparam int AW = DATA_WIDTH + PACE_LOG2;
    logic [AW-1:0] acc, acc_nxt, acc_sum, acc_shr;
    assign acc_sum = acc + AW'(adc_data_i);
    assign acc_shr = acc_sum >> PACE_LOG2;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARM;
                ARM:     if (adc_vld_i) state_nxt = RUN;
                RUN:     if (gap_hit) state_nxt = ARM;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        win_cnt_nxt  = win_cnt;
        gap_cnt_nxt  = gap_cnt;
        src_vld_nxt  = 1'b0;
        stall_nxt    = 1'b0;
        src_data_nxt = src_data_o;
`ifdef PACER_AVERAGE_EN
        acc_nxt      = acc;
`endif
        if (!en_i || state == IDLE) begin
            // Disable discards any partial window.
            win_cnt_nxt = '0;
            gap_cnt_nxt = '0;
`ifdef PACER_AVERAGE_EN
            acc_nxt     = '0;
`endif
        end else if (accept) begin
            win_cnt_nxt = win_cnt + PACE_LOG2'(1);
            gap_cnt_nxt = '0;
`ifdef PACER_AVERAGE_EN
            acc_nxt     = acc_sum;
`endif
            if (close) begin
                src_vld_nxt  = 1'b1;
`ifdef PACER_AVERAGE_EN
                src_data_nxt = acc_shr[DATA_WIDTH-1:0];
                acc_nxt      = '0;
`else
                src_data_nxt = adc_data_i;
`endif
            end
        end else if (gap_hit) begin
            stall_nxt   = 1'b1;
            win_cnt_nxt = '0;
            gap_cnt_nxt = '0;
`ifdef PACER_AVERAGE_EN
            acc_nxt     = '0;
`endif
        end else if (state == RUN) begin
            if (gap_cnt != GAP_SAT) gap_cnt_nxt = gap_cnt + GW'(1);
        end else begin
            gap_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_cnt    <= '0;
            gap_cnt    <= '0;
            src_vld_o  <= 1'b0;
            src_data_o <= '0;
            stall_o    <= 1'b0;
`ifdef PACER_AVERAGE_EN
            acc        <= '0;
`endif
        end else begin
            win_cnt    <= win_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            src_vld_o  <= src_vld_nxt;
            src_data_o <= src_data_nxt;
            stall_o    <= stall_nxt;
`ifdef PACER_AVERAGE_EN
            acc        <= acc_nxt;
`endif
        end
    end

    assign win_cnt_o = win_cnt;

endmodule

// File: tb/tb_src_pacer.sv
// Directed bench for src_pacer: reset, pacing, sparse input, gap timeout, disable and reset mid-window.
module tb_src_pacer;
    logic        clk = 1'b0;
    logic        rst, en, adc_vld;
    logic [15:0] adc_data;
    logic        src_vld, stall;
    logic [15:0] src_data;
    logic [4:0]  win_cnt;
    int          total = 0;
    int          bad   = 0;
    int          n;
    logic [15:0] last;

    src_pacer #(.DATA_WIDTH(16), .PACE_LOG2(5), .GAP_MAX(64)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .adc_vld_i(adc_vld), .adc_data_i(adc_data),
        .src_vld_o(src_vld), .src_data_o(src_data), .stall_o(stall), .win_cnt_o(win_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d);
        adc_vld  = v;
        adc_data = d;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; drive(1'b0, 16'h0);
        tick(); tick();
        chk("rst_vld", 32'(src_vld), 32'd0);
        chk("rst_dat", 32'(src_data), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_win", 32'(win_cnt), 32'd0);

        // Disabled: toggling input never produces a strobe.
        rst = 1'b0; n = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'(i % 2), 16'(i + 3));
            tick();
            if (src_vld) n++;
        end
        chk("idle_strobes", 32'(n), 32'd0);
        chk("idle_dat", 32'(src_data), 32'd0);
        chk("idle_win", 32'(win_cnt), 32'd0);

        // Ramp, one sample per cycle.
        en = 1'b1; drive(1'b0, 16'h0); tick();
        last = 16'd0;
        for (int i = 0; i < 96; i++) begin
            drive(1'b1, 16'(i));
            tick();
            chk("pace_vld", 32'(src_vld), 32'(i % 32 == 31));
            chk("pace_win", 32'(win_cnt), 32'((i + 1) % 32));
`ifdef PACER_AVERAGE_EN
            if (i % 32 == 31) last = 16'(i - 16);
`else
            if (i % 32 == 31) last = 16'(i);
`endif
            chk("pace_dat", 32'(src_data), 32'(last));
        end
        drive(1'b0, 16'h0); tick();
        chk("pace_hold_vld", 32'(src_vld), 32'd0);
        chk("pace_hold_dat", 32'(src_data), 32'(last));
        en = 1'b0; tick();
        chk("off_win", 32'(win_cnt), 32'd0);

        // Sparse: one sample every 4 cycles.
        en = 1'b1; tick();
        n = 0;
        for (int s = 0; s < 32; s++) begin
            for (int c = 0; c < 4; c++) begin
                drive(c == 0, 16'h1234);
                tick();
                if (src_vld) begin
                    n++;
                    chk("sparse_dat", 32'(src_data), 32'h1234);
                end
            end
        end
        chk("sparse_strobes", 32'(n), 32'd1);
        en = 1'b0; drive(1'b0, 16'h0); tick();

        // Gap timeout after 10 samples.
        en = 1'b1; tick();
        for (int i = 0; i < 10; i++) begin drive(1'b1, 16'd7); tick(); end
        chk("gap_win10", 32'(win_cnt), 32'd10);
        drive(1'b0, 16'h0); n = 0;
        for (int i = 0; i < 63; i++) begin tick(); if (stall) n++; end
        chk("gap_early_stall", 32'(n), 32'd0);
        tick();
        chk("gap_stall", 32'(stall), 32'd1);
        chk("gap_win0", 32'(win_cnt), 32'd0);
        tick();
        chk("gap_stall_pulse", 32'(stall), 32'd0);
        n = 0;
        for (int k = 0; k < 32; k++) begin
            drive(1'b1, 16'(100 + k));
            tick();
            if (src_vld) n++;
        end
        chk("gap_win_strobes", 32'(n), 32'd1);
        chk("gap_win_last_vld", 32'(src_vld), 32'd1);
`ifdef PACER_AVERAGE_EN
        chk("gap_win_dat", 32'(src_data), 32'd115);
`else
        chk("gap_win_dat", 32'(src_data), 32'd131);
`endif
        // Sample on the 64th gap cycle prevents the stall.
        drive(1'b0, 16'h0); n = 0;
        for (int i = 0; i < 63; i++) begin tick(); if (stall) n++; end
        drive(1'b1, 16'd50); tick(); if (stall) n++;
        drive(1'b0, 16'h0); tick(); if (stall) n++;
        chk("gap_saved_stall", 32'(n), 32'd0);
        chk("gap_saved_win", 32'(win_cnt), 32'd1);
        en = 1'b0; tick();

        // Disable after 20 samples, re-enable after 5 cycles.
        en = 1'b1; tick();
        for (int i = 0; i < 20; i++) begin drive(1'b1, 16'd5); tick(); end
        chk("dis_win20", 32'(win_cnt), 32'd20);
        en = 1'b0; n = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (src_vld) n++; end
        chk("dis_strobes", 32'(n), 32'd0);
        chk("dis_win", 32'(win_cnt), 32'd0);
        en = 1'b1; drive(1'b0, 16'h0); tick();
        for (int k = 0; k < 32; k++) begin
            drive(1'b1, 16'(200 + k));
            tick();
            chk("rearm_vld", 32'(src_vld), 32'(k == 31));
        end
`ifdef PACER_AVERAGE_EN
        last = 16'd215;
`else
        last = 16'd231;
`endif
        chk("rearm_dat", 32'(src_data), 32'(last));

        // en_i falls together with the closing sample.
        for (int i = 0; i < 31; i++) begin drive(1'b1, 16'd3); tick(); end
        en = 1'b0; tick();
        chk("enfall_vld", 32'(src_vld), 32'd0);
        chk("enfall_win", 32'(win_cnt), 32'd0);
        chk("enfall_dat", 32'(src_data), 32'(last));

        // Reset with the closing sample.
        en = 1'b1; drive(1'b0, 16'h0); tick();
        for (int i = 0; i < 31; i++) begin drive(1'b1, 16'd9); tick(); end
        chk("rstmid_win31", 32'(win_cnt), 32'd31);
        rst = 1'b1; drive(1'b1, 16'd9); tick();
        chk("rstmid_vld", 32'(src_vld), 32'd0);
        chk("rstmid_dat", 32'(src_data), 32'd0);
        chk("rstmid_stall", 32'(stall), 32'd0);
        chk("rstmid_win", 32'(win_cnt), 32'd0);
        rst = 1'b0; en = 1'b0; drive(1'b0, 16'h0); tick();
        chk("post_vld", 32'(src_vld), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
